// File: rtl/membus_arbiter_n_if.sv
// membus_arbiter_n_if: requester, response and downstream memory signals of the N-channel arbiter.
// slave modport is the arbiter's view; master modport is the requester/memory side.
interface membus_arbiter_n_if #(
  parameter int NCH    = 4,
  parameter int ADDR_W = 32
);
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_ready;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH-1:0]        req_wen;
  logic [NCH*32-1:0]     req_wdata;
  logic [NCH*4-1:0]      req_wmask;
  logic [NCH-1:0]        resp_valid;
  logic                  resp_error;
  logic [31:0]           resp_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_req_wen;
  logic [31:0]           mem_req_wdata;
  logic [3:0]            mem_req_wmask;
  logic                  mem_resp_valid;
  logic                  mem_resp_error;
  logic [31:0]           mem_resp_rdata;
  logic                  unexpected_resp;
  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_error, mem_resp_rdata,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output unexpected_resp
  );
  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_error, mem_resp_rdata,
    input  req_ready, resp_valid, resp_error, resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  unexpected_resp
  );
endinterface

// File: rtl/membus_arbiter_n.sv
// membus_arbiter_n: round-robin arbiter of NCH requesters onto one memory port with in-order response routing.
// Ports: clk, reset_n (async active-low), bus (membus_arbiter_n_if.slave: requester, response and memory signals).
module membus_arbiter_n #(
  parameter int NCH     = 4,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4
) (
  input logic               clk,
  input logic               reset_n,
  membus_arbiter_n_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int PW = $clog2(MAX_OUT);
  typedef enum logic {ARB, HOLD} state_t;
  state_t        state, state_n;
  logic [CW-1:0] rr_ptr, locked_ch, rr_grant, grant, idx;
  logic [CW-1:0] ids [MAX_OUT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, offer, push, pop, unexp;
  // Reverse scan so the last hit is the first valid channel at or after rr_ptr.
  always_comb begin
    rr_grant = rr_ptr;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = CW'((int'(rr_ptr) + i) % NCH);
      if (bus.req_valid[idx]) rr_grant = idx;
    end
  end
  // HOLD pins the grant while an offered request waits for mem_req_ready.
  always_comb begin
    state_n = push ? ARB : offer ? HOLD : state;
  end
  assign grant = (state == HOLD) ? locked_ch : rr_grant;
  assign full  = count == (PW+1)'(MAX_OUT);
  assign offer = reset_n & bus.req_valid[grant] & ~full;
  assign push  = offer & bus.mem_req_ready;
  assign pop   = reset_n & bus.mem_resp_valid & (count != '0);
  assign bus.mem_req_valid   = offer;
  assign bus.mem_req_addr    = reset_n ? bus.req_addr[int'(grant)*ADDR_W +: ADDR_W] : '0;
  assign bus.mem_req_wen     = reset_n & bus.req_wen[grant];
  assign bus.mem_req_wdata   = reset_n ? bus.req_wdata[int'(grant)*32 +: 32] : '0;
  assign bus.mem_req_wmask   = reset_n ? bus.req_wmask[int'(grant)*4 +: 4] : '0;
  assign bus.req_ready       = push ? NCH'(1) << grant : '0;
  assign bus.resp_valid      = pop ? NCH'(1) << ids[rd_ptr] : '0;
  assign bus.resp_error      = pop & bus.mem_resp_error;
  assign bus.resp_rdata      = pop ? bus.mem_resp_rdata : '0;
  assign bus.unexpected_resp = unexp;
  always_ff @(posedge clk) begin
    if (push) ids[wr_ptr] <= grant;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      rr_ptr    <= '0;
      locked_ch <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      unexp     <= 1'b0;
    end else begin
      state <= state_n;
      if (offer && !bus.mem_req_ready) locked_ch <= grant;
      if (push) rr_ptr <= (grant == CW'(NCH - 1)) ? '0 : grant + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (bus.mem_resp_valid && count == '0) unexp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_membus_arbiter_n.sv
// tb_membus_arbiter_n: directed scoreboard bench for membus_arbiter_n.
module tb_membus_arbiter_n;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  membus_arbiter_n_if #(.NCH(4), .ADDR_W(32)) bus();
  membus_arbiter_n #(.NCH(4), .ADDR_W(32), .MAX_OUT(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int vectors = 0;
  int errors = 0;
  logic [35:0] exp_req[$];
  logic [35:0] exp_resp[$];
  logic [35:0] me;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_req.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL req_extra: got %0h expected none", {bus.req_ready, bus.mem_req_addr});
        end else begin
          me = exp_req.pop_front();
          check("req_xfer", {bus.req_ready, bus.mem_req_addr}, me);
        end
      end
      if (bus.resp_valid != '0) begin
        if (exp_resp.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL resp_extra: got %0h expected none", {bus.resp_valid, bus.resp_rdata});
        end else begin
          me = exp_resp.pop_front();
          check("resp", {bus.resp_valid, bus.resp_rdata}, me);
        end
      end
    end
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic set_ch(input int c, input logic v, input logic [31:0] a);
    bus.req_valid[c] = v;
    bus.req_addr[c*32 +: 32] = a;
  endtask
  task automatic req(input int c, input logic [31:0] a);
    set_ch(c, 1'b1, a);
    exp_req.push_back({4'(1 << c), a});
    nxt();
    set_ch(c, 1'b0, 32'h0);
  endtask
  task automatic resp(input logic [31:0] d, input logic [3:0] who);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = d;
    exp_resp.push_back({who, d});
    nxt();
    bus.mem_resp_valid = 1'b0;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_wen = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_error = 1'b0;
    bus.mem_resp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 4'hF;
    bus.req_addr = {4{32'hDEAD0000}};
    bus.mem_req_ready = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1234;
    @(negedge clk);
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_mem_req_addr", bus.mem_req_addr, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_unexpected", bus.unexpected_resp, 0);
    nxt();
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    reset_n = 1'b1;
    nxt();
    // round robin between ch1 and ch3
    bus.mem_req_ready = 1'b1;
    set_ch(1, 1'b1, 32'h1000);
    set_ch(3, 1'b1, 32'h3000);
    for (int k = 0; k < 4; k++) begin
      exp_req.push_back((k % 2 == 0) ? {4'b0010, 32'h1000} : {4'b1000, 32'h3000});
      @(negedge clk);
      check("t1_ready_onehot", $countones(bus.req_ready), 1);
      nxt();
    end
    set_ch(1, 1'b0, 32'h0);
    set_ch(3, 1'b0, 32'h0);
    resp(32'h11, 4'b0010);
    resp(32'h12, 4'b1000);
    resp(32'h13, 4'b0010);
    resp(32'h14, 4'b1000);
    // stall holds ch0 even after ch2 arrives
    bus.mem_req_ready = 1'b0;
    set_ch(0, 1'b1, 32'h100);
    @(negedge clk);
    check("t2_addr_c0", bus.mem_req_addr, 32'h100);
    check("t2_ready_stall", bus.req_ready, 0);
    nxt();
    set_ch(2, 1'b1, 32'h200);
    @(negedge clk);
    check("t2_addr_c1", bus.mem_req_addr, 32'h100);
    check("t2_valid_c1", bus.mem_req_valid, 1);
    nxt();
    @(negedge clk);
    check("t2_addr_c2", bus.mem_req_addr, 32'h100);
    nxt();
    bus.mem_req_ready = 1'b1;
    exp_req.push_back({4'b0001, 32'h100});
    @(negedge clk);
    check("t2_accept_c0", bus.req_ready, 4'b0001);
    nxt();
    set_ch(0, 1'b0, 32'h0);
    exp_req.push_back({4'b0100, 32'h200});
    @(negedge clk);
    check("t2_grant_c2", bus.req_ready, 4'b0100);
    nxt();
    set_ch(2, 1'b0, 32'h0);
    resp(32'h21, 4'b0001);
    resp(32'h22, 4'b0100);
    // fill the ID FIFO
    for (int k = 0; k < 4; k++) req(0, 32'h400 + 32'(4 * k));
    set_ch(0, 1'b1, 32'h410);
    @(negedge clk);
    check("t3_full_valid", bus.mem_req_valid, 0);
    check("t3_full_ready", bus.req_ready, 0);
    check("t3_full_count", dut.count, 4);
    nxt();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h31;
    exp_resp.push_back({4'b0001, 32'h31});
    @(negedge clk);
    check("t3_pop_still_full", bus.mem_req_valid, 0);
    nxt();
    bus.mem_resp_valid = 1'b0;
    exp_req.push_back({4'b0001, 32'h410});
    @(negedge clk);
    check("t3_after_pop", bus.mem_req_valid, 1);
    nxt();
    set_ch(0, 1'b0, 32'h0);
    resp(32'h32, 4'b0001);
    resp(32'h33, 4'b0001);
    resp(32'h34, 4'b0001);
    resp(32'h35, 4'b0001);
    // ch2, ch0 (write), ch2 in order
    req(2, 32'h500);
    bus.req_wen[0] = 1'b1;
    bus.req_wdata[31:0] = 32'hCAFEF00D;
    bus.req_wmask[3:0] = 4'b0101;
    set_ch(0, 1'b1, 32'h504);
    exp_req.push_back({4'b0001, 32'h504});
    @(negedge clk);
    check("t4_wen", bus.mem_req_wen, 1);
    check("t4_wdata", bus.mem_req_wdata, 32'hCAFEF00D);
    check("t4_wmask", bus.mem_req_wmask, 4'b0101);
    nxt();
    set_ch(0, 1'b0, 32'h0);
    bus.req_wen = '0;
    req(2, 32'h508);
    resp(32'hA, 4'b0100);
    resp(32'hB, 4'b0001);
    resp(32'hC, 4'b0100);
    // simultaneous push and pop
    req(3, 32'h600);
    req(0, 32'h604);
    check("t5_count_before", dut.count, 2);
    set_ch(1, 1'b1, 32'h608);
    exp_req.push_back({4'b0010, 32'h608});
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h55;
    exp_resp.push_back({4'b1000, 32'h55});
    @(negedge clk);
    check("t5_resp_valid", bus.resp_valid, 4'b1000);
    nxt();
    set_ch(1, 1'b0, 32'h0);
    bus.mem_resp_valid = 1'b0;
    check("t5_count_after", dut.count, 2);
    resp(32'h56, 4'b0001);
    resp(32'h57, 4'b0010);
    // unexpected response and reset with outstanding IDs
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h66;
    @(negedge clk);
    check("t6_no_resp", bus.resp_valid, 0);
    nxt();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t6_sticky", bus.unexpected_resp, 1);
    nxt();
    req(1, 32'h700);
    req(1, 32'h704);
    req(1, 32'h708);
    check("t6_sticky_hold", bus.unexpected_resp, 1);
    check("t6_count3", dut.count, 3);
    set_ch(1, 1'b1, 32'h70C);
    bus.mem_resp_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.mem_req_valid, 0);
    check("t6_rst_ready", bus.req_ready, 0);
    check("t6_rst_addr", bus.mem_req_addr, 0);
    check("t6_rst_resp", bus.resp_valid, 0);
    check("t6_rst_unexp", bus.unexpected_resp, 0);
    check("t6_rst_count", dut.count, 0);
    nxt();
    set_ch(1, 1'b0, 32'h0);
    bus.mem_resp_valid = 1'b0;
    reset_n = 1'b1;
    nxt();
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    check("t6_late_no_resp", bus.resp_valid, 0);
    nxt();
    bus.mem_resp_valid = 1'b0;
    check("t6_late_unexp", bus.unexpected_resp, 1);
    check("req_queue_drained", exp_req.size(), 0);
    check("resp_queue_drained", exp_resp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
